// File: rtl/synfifo_gen2_if.sv
// rtl/synfifo_gen2_if.sv - handshake/status bundle for synfifo_gen2
// Ports (members):
//   master drives wr, wr_data, rd, flush, err_clr, cfg_almost_full and cfg_almost_empty.
//   master receives rd_data, rd_data_vld, the full/empty/almost flags, fifo_num,
//   overflow, underflow and peak_num.
//   slave (the FIFO) uses the opposite directions.
interface synfifo_gen2_if #(
    parameter int data_width  = 8,
    parameter int depth_width = 3
);
    logic                   wr;
    logic [data_width-1:0]  wr_data;
    logic                   rd;
    logic                   flush;
    logic                   err_clr;
    logic [depth_width-1:0] cfg_almost_full;
    logic [depth_width-1:0] cfg_almost_empty;
    logic [data_width-1:0]  rd_data;
    logic                   rd_data_vld;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [depth_width-1:0] fifo_num;
    logic                   overflow;
    logic                   underflow;
    logic [depth_width-1:0] peak_num;

    modport master (
        output wr, wr_data, rd, flush, err_clr, cfg_almost_full, cfg_almost_empty,
        input  rd_data, rd_data_vld, full, empty, almost_full, almost_empty,
               fifo_num, overflow, underflow, peak_num
    );

    modport slave (
        input  wr, wr_data, rd, flush, err_clr, cfg_almost_full, cfg_almost_empty,
        output rd_data, rd_data_vld, full, empty, almost_full, almost_empty,
               fifo_num, overflow, underflow, peak_num
    );
endinterface

// File: rtl/synfifo_gen2.sv
// rtl/synfifo_gen2.sv - synchronous FIFO with any depth, std/FWFT read, flush, sticky errors, peak tracking
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  synfifo_gen2_if.slave: push/pop/flush/err_clr requests, thresholds,
//        read data with qualifier, occupancy flags, sticky errors, peak occupancy
module synfifo_gen2 #(
    parameter int data_width  = 8,
    parameter int data_depth  = 6,
    parameter int depth_width = 3,
    parameter bit fwft_mode   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    synfifo_gen2_if.slave bus
);
    localparam logic [depth_width-1:0] last_idx  = depth_width'(data_depth - 1);
    localparam logic [depth_width-1:0] depth_val = depth_width'(data_depth);

    logic [data_width-1:0]  mem_q [data_depth];
    logic [depth_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_width-1:0] num_q, num_d;
    logic [depth_width-1:0] peak_q, peak_d;
    logic [data_width-1:0]  rd_data_q, rd_data_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    logic full_w, empty_w, pop_ok, push_ok, ovf_evt, udf_evt;

    assign full_w  = (num_q == depth_val);
    assign empty_w = (num_q == '0);

    // Flush masks every request so it can neither move data nor raise an error.
    assign pop_ok  = ~bus.flush & bus.rd & ~empty_w;
    assign push_ok = ~bus.flush & bus.wr & (~full_w | pop_ok);
    assign ovf_evt = ~bus.flush & bus.wr & full_w & ~pop_ok;
    assign udf_evt = ~bus.flush & bus.rd & empty_w;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        num_d     = num_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            num_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == last_idx) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d  = (rd_ptr_q == last_idx) ? '0 : rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
                rd_vld_d  = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   num_d = num_q + 1'b1;
                2'b01:   num_d = num_q - 1'b1;
                default: num_d = num_q;
            endcase
        end
        // A new event wins over a coincident clear.
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_evt;
        udf_d = (udf_q & ~bus.err_clr) | udf_evt;
        if (bus.err_clr) begin
            peak_d = num_d;
        end else begin
            peak_d = (num_d > peak_q) ? num_d : peak_q;
        end
    end

    // Storage is cleared on reset so the FWFT read port also shows 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < data_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            num_q     <= '0;
            peak_q    <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            num_q     <= num_d;
            peak_q    <= peak_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign bus.rd_data      = fwft_mode ? mem_q[rd_ptr_q] : rd_data_q;
    assign bus.rd_data_vld  = fwft_mode ? ~empty_w : rd_vld_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (num_q >= bus.cfg_almost_full);
    assign bus.almost_empty = (num_q <= bus.cfg_almost_empty);
    assign bus.fifo_num     = num_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.peak_num     = peak_q;
endmodule

// File: tb/tb_synfifo_gen2.sv
// tb/tb_synfifo_gen2.sv - self-checking bench for synfifo_gen2 in standard and FWFT modes
module tb_synfifo_gen2;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    synfifo_gen2_if #(.data_width(8), .depth_width(3)) bs ();
    synfifo_gen2_if #(.data_width(8), .depth_width(3)) bf ();

    synfifo_gen2 #(.data_width(8), .data_depth(6), .depth_width(3), .fwft_mode(1'b0))
        u_std (.clk(clk), .rst(rst), .bus(bs.slave));
    synfifo_gen2 #(.data_width(8), .data_depth(6), .depth_width(3), .fwft_mode(1'b1))
        u_fwft (.clk(clk), .rst(rst), .bus(bf.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of bytes plus the sticky/peak state.
    logic [7:0] q[$];
    logic       ovf_m, udf_m;
    int         peak_m;
    logic [7:0] rd_m;
    logic       vld_m;
    logic [2:0] caf, cae;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        peak_m = 0;
        rd_m   = 8'h00;
        vld_m  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":s.num"},  32'(bs.fifo_num), 32'(n));
        chk({tag, ":s.full"}, 32'(bs.full), 32'(n == 6));
        chk({tag, ":s.empty"}, 32'(bs.empty), 32'(n == 0));
        chk({tag, ":s.af"},   32'(bs.almost_full), 32'(n >= int'(caf)));
        chk({tag, ":s.ae"},   32'(bs.almost_empty), 32'(n <= int'(cae)));
        chk({tag, ":s.ovf"},  32'(bs.overflow), 32'(ovf_m));
        chk({tag, ":s.udf"},  32'(bs.underflow), 32'(udf_m));
        chk({tag, ":s.peak"}, 32'(bs.peak_num), 32'(peak_m));
        chk({tag, ":s.vld"},  32'(bs.rd_data_vld), 32'(vld_m));
        chk({tag, ":s.data"}, 32'(bs.rd_data), 32'(rd_m));
        chk({tag, ":f.num"},  32'(bf.fifo_num), 32'(n));
        chk({tag, ":f.ovf"},  32'(bf.overflow), 32'(ovf_m));
        chk({tag, ":f.udf"},  32'(bf.underflow), 32'(udf_m));
        chk({tag, ":f.peak"}, 32'(bf.peak_num), 32'(peak_m));
        chk({tag, ":f.vld"},  32'(bf.rd_data_vld), 32'(n != 0));
        if (n != 0) chk({tag, ":f.data"}, 32'(bf.rd_data), 32'(q[0]));
    endtask

    // Applies one cycle of stimulus to both FIFOs (called at a falling edge),
    // advances the model, then checks at the following falling edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic f, input logic ec);
        int  n;
        logic pop, push, ev_o, ev_u;
        bs.wr = w; bs.wr_data = d; bs.rd = r; bs.flush = f; bs.err_clr = ec;
        bf.wr = w; bf.wr_data = d; bf.rd = r; bf.flush = f; bf.err_clr = ec;
        bs.cfg_almost_full = caf; bs.cfg_almost_empty = cae;
        bf.cfg_almost_full = caf; bf.cfg_almost_empty = cae;
        n = q.size();
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (f) begin
            q.delete();
            vld_m = 1'b0;
        end else begin
            pop  = r && (n > 0);
            push = w && ((n < 6) || pop);
            ev_o = w && (n == 6) && !pop;
            ev_u = r && (n == 0);
            if (pop) begin
                rd_m  = q.pop_front();
                vld_m = 1'b1;
            end else begin
                vld_m = 1'b0;
            end
            if (push) q.push_back(d);
        end
        ovf_m = (ovf_m & ~ec) | ev_o;
        udf_m = (udf_m & ~ec) | ev_u;
        if (ec) peak_m = q.size();
        else if (q.size() > peak_m) peak_m = q.size();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
        bs.wr = 1'b0; bs.rd = 1'b0; bs.flush = 1'b0; bs.err_clr = 1'b0;
        bf.wr = 1'b0; bf.rd = 1'b0; bf.flush = 1'b0; bf.err_clr = 1'b0;
    endtask

    initial begin
        caf = 3'd5;
        cae = 3'd1;
        rst = 1'b1;
        bs.wr = 1'b0; bs.wr_data = '0; bs.rd = 1'b0; bs.flush = 1'b0; bs.err_clr = 1'b0;
        bf.wr = 1'b0; bf.wr_data = '0; bf.rd = 1'b0; bf.flush = 1'b0; bf.err_clr = 1'b0;
        bs.cfg_almost_full = caf; bs.cfg_almost_empty = cae;
        bf.cfg_almost_full = caf; bf.cfg_almost_empty = cae;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset:f.data", 32'(bf.rd_data), 32'h0);
        rst = 1'b0;

        // Standard fill and drain.
        for (int i = 0; i < 6; i++) step("fill", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        chk("fill:full", 32'(bs.full), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain:order", 32'(bs.rd_data), 32'(8'h11 + i));
        end
        chk("drain:peak", 32'(bs.peak_num), 32'd6);

        // Wrap-around at occupancy 3.
        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step("wrap_push", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            else begin
                step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                chk("wrap:num3", 32'(bs.fifo_num), 32'd3);
            end
        end

        // Full with simultaneous wr & rd, then wr alone, then err_clr.
        for (int i = 0; i < 3; i++) step("to_full", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        chk("full_wr_rd:num", 32'(bs.fifo_num), 32'd6);
        step("full_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("full_wr:ovf", 32'(bs.overflow), 32'h1);
        step("err_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("err_clr:peak", 32'(bs.peak_num), 32'd6);

        // Empty with simultaneous wr & rd.
        step("flush_e", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("empty_wr_rd", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("empty_wr_rd:udf", 32'(bs.underflow), 32'h1);

        // FWFT presentation and acknowledge.
        step("flush_f", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step("fwft_push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft:data", 32'(bf.rd_data), 32'hA5);
        step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_rd:empty", 32'(bf.empty), 32'h1);

        // Flush together with wr at occupancy 4.
        for (int i = 0; i < 4; i++) step("pre_flush", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("flush_wr:num", 32'(bs.fifo_num), 32'd0);

        // Asynchronous reset at occupancy 3.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("rst_async");
        chk("rst_async:f.data", 32'(bf.rd_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic, thresholds changing occasionally.
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) begin
                caf = 3'($urandom_range(0, 7));
                cae = 3'($urandom_range(0, 7));
            end
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
